// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared types and constants for the Life host and core
package conway_pkg;

  localparam int CONWAY_CELLS = 64;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_STEP = 2'b10,
    MODE_READ = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    READ,
    DONE
  } host_state_t;

endpackage

// File: rtl/conway_shift_reg.sv
// rtl/conway_shift_reg.sv - parallel-load, right-shifting register; serial in enters at the MSB
module conway_shift_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_data;
    end else if (shift_en) begin
      r_q <= {serial_in, r_q[WIDTH-1:1]};
    end
  end

  assign q          = r_q;
  assign serial_out = r_q[0];

endmodule

// File: rtl/conway_serial_host.sv
// rtl/conway_serial_host.sv - host driver for the Life core serial port (optional CONWAY_HOST_POPCOUNT_EN)
module conway_serial_host
  import conway_pkg::*;
#(
  parameter int CELLS    = CONWAY_CELLS,
  parameter int GEN_W    = 8,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CELLS-1:0] board_in,
  input  logic [GEN_W-1:0] gens_in,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             data_in,
  output logic [1:0]       mode,
  input  logic             data_out,
  output logic [CELLS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
`ifdef CONWAY_HOST_POPCOUNT_EN
  ,
  output logic [$clog2(CELLS+1)-1:0] live_count
`endif
);

  localparam int CNT_W = $clog2(CELLS + READ_LAT + 1);
  localparam int LC_W  = $clog2(CELLS + 1);

  host_state_t      r_state;
  mode_t            r_mode;
  logic             r_start_ready;
  logic             r_busy;
  logic             r_result_valid;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [GEN_W-1:0] r_gen_cnt;

  logic             w_accept;
  logic             w_load_en;
  logic             w_cap_en;
  logic             w_load_sout;
  logic [CELLS-1:0] w_load_q_unused;
  logic             w_cap_sout_unused;
  logic [CELLS-1:0] w_cap_q;

  assign w_accept  = start_valid && r_start_ready;
  assign w_load_en = (r_state == LOAD);
  // The core needs READ_LAT cycles before cell 0 is on data_out.
  assign w_cap_en  = (r_state == READ) && (r_bit_cnt >= CNT_W'(READ_LAT));

  conway_shift_reg #(.WIDTH(CELLS)) u_load_sr (
    .clk        (clk),
    .reset      (reset),
    .load       (w_accept),
    .load_data  (board_in),
    .shift_en   (w_load_en),
    .serial_in  (1'b0),
    .serial_out (w_load_sout),
    .q          (w_load_q_unused)
  );

  conway_shift_reg #(.WIDTH(CELLS)) u_cap_sr (
    .clk        (clk),
    .reset      (reset),
    .load       (1'b0),
    .load_data  ({CELLS{1'b0}}),
    .shift_en   (w_cap_en),
    .serial_in  (data_out),
    .serial_out (w_cap_sout_unused),
    .q          (w_cap_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_mode         <= MODE_HOLD;
      r_start_ready  <= 1'b1;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_bit_cnt      <= '0;
      r_gen_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state       <= LOAD;
            r_mode        <= MODE_LOAD;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
            r_bit_cnt     <= '0;
            r_gen_cnt     <= gens_in;
          end
        end
        LOAD: begin
          if (r_bit_cnt == CNT_W'(CELLS - 1)) begin
            r_bit_cnt <= '0;
            if (r_gen_cnt != '0) begin
              r_state <= STEP;
              r_mode  <= MODE_STEP;
            end else begin
              r_state <= READ;
              r_mode  <= MODE_READ;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        STEP: begin
          r_gen_cnt <= r_gen_cnt - GEN_W'(1);
          if (r_gen_cnt == GEN_W'(1)) begin
            r_state <= READ;
            r_mode  <= MODE_READ;
          end
        end
        READ: begin
          if (r_bit_cnt == CNT_W'(CELLS + READ_LAT - 1)) begin
            r_bit_cnt      <= '0;
            r_state        <= DONE;
            r_mode         <= MODE_HOLD;
            r_result_valid <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            r_state        <= IDLE;
            r_result_valid <= 1'b0;
            r_start_ready  <= 1'b1;
            r_busy         <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_mode  <= MODE_HOLD;
        end
      endcase
    end
  end

`ifdef CONWAY_HOST_POPCOUNT_EN
  logic [LC_W-1:0] r_live_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live_count <= '0;
    end else if (w_accept) begin
      r_live_count <= '0;
    end else if (w_cap_en && data_out) begin
      r_live_count <= r_live_count + LC_W'(1);
    end
  end

  assign live_count = r_live_count;
`endif

  // Load register drains to zero during LOAD, so data_in idles low.
  assign data_in      = w_load_sout;
  assign mode         = r_mode;
  assign start_ready  = r_start_ready;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result       = w_cap_q;

endmodule

// File: tb/tb_conway_serial_host.sv
// tb/tb_conway_serial_host.sv - self-checking bench for conway_serial_host with a behavioural Life core
module tb_conway_serial_host;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] board_in;
  logic [7:0]  gens_in;
  logic        start_valid;
  logic        start_ready;
  logic        data_in;
  logic [1:0]  mode;
  logic        data_out;
  logic [63:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
`ifdef CONWAY_HOST_POPCOUNT_EN
  logic [6:0]  live_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] core_q = '0;

  conway_serial_host dut (
    .clk          (clk),
    .reset        (reset),
    .board_in     (board_in),
    .gens_in      (gens_in),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .data_in      (data_in),
    .mode         (mode),
    .data_out     (data_out),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
`ifdef CONWAY_HOST_POPCOUNT_EN
    ,
    .live_count   (live_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] life_step(input logic [63:0] b);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < 8 && (c + dc) >= 0 && (c + dc) < 8)
              cnt += int'(b[(r + dr) * 8 + (c + dc)]);
          end
        end
        n[r * 8 + c] = (cnt == 3) || (b[r * 8 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] life_n(input logic [63:0] b, input int g);
    logic [63:0] x;
    x = b;
    for (int i = 0; i < g; i++) x = life_step(x);
    return x;
  endfunction

  // Behavioural core: shift-in on LOAD, one generation per STEP, registered serial out on READ.
  always @(posedge clk) begin
    case (mode)
      2'b01: core_q <= {data_in, core_q[63:1]};
      2'b10: core_q <= life_step(core_q);
      2'b11: begin
        data_out <= core_q[0];
        core_q   <= {core_q[0], core_q[63:1]};
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_only(input logic [63:0] b, input int g);
    @(negedge clk);
    board_in    = b;
    gens_in     = 8'(g);
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    board_in    = {$urandom, $urandom};
    gens_in     = 8'($urandom);
  endtask

  task automatic run_job(input string tag, input logic [63:0] b, input int g,
                         input logic [63:0] exp, input int hold);
    int nl, ns, nr, phase, budget;
    bit order_ok;
    nl = 0; ns = 0; nr = 0; phase = 0; order_ok = 1'b1;
    start_only(b, g);
    budget = 64 + g + 65 + 10;
    while (!result_valid && budget > 0) begin
      case (mode)
        2'b01: begin nl++; if (phase > 1) order_ok = 1'b0; phase = 1; end
        2'b10: begin ns++; if (phase != 1 && phase != 2) order_ok = 1'b0; phase = 2; end
        2'b11: begin nr++; if (phase < 1) order_ok = 1'b0; phase = 3; end
        default: order_ok = 1'b0;
      endcase
      budget--;
      @(negedge clk);
    end
    chk({tag, " done"}, 64'(result_valid), 64'd1);
    chk({tag, " load_cycles"}, 64'(nl), 64'd64);
    chk({tag, " step_cycles"}, 64'(ns), 64'(g));
    chk({tag, " read_cycles"}, 64'(nr), 64'd65);
    chk({tag, " phase_order"}, 64'(order_ok), 64'd1);
    chk({tag, " result"}, result, exp);
    chk({tag, " done_mode"}, 64'(mode), 64'd0);
`ifdef CONWAY_HOST_POPCOUNT_EN
    chk({tag, " live_count"}, 64'(live_count), 64'($countones(exp)));
`endif
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'($urandom);
      @(negedge clk);
      chk({tag, " hold_result"}, result, exp);
      chk({tag, " hold_start_ready"}, 64'(start_ready), 64'd0);
      chk({tag, " hold_valid"}, 64'(result_valid), 64'd1);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, " idle_start_ready"}, 64'(start_ready), 64'd1);
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
    chk({tag, " idle_result_kept"}, result, exp);
  endtask

  typedef struct {
    logic [63:0] board;
    int          gens;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [63:0] rb;
    int          rg;

    tbl[0] = '{64'h0000_0000_1C00_0000, 1, 64'h0000_0008_0808_0000};
    tbl[1] = '{64'h0000_0000_1C00_0000, 0, 64'h0000_0000_1C00_0000};
    tbl[2] = '{64'hA5A5_5A5A_0F0F_F0F0, 2, life_n(64'hA5A5_5A5A_0F0F_F0F0, 2)};
    tbl[3] = '{64'h0000_0000_1C00_0000, 2, 64'h0000_0000_1C00_0000};
    tbl[4] = '{64'h0000_0000_0018_1800, 3, 64'h0000_0000_0018_1800};

    reset        = 1'b1;
    board_in     = '0;
    gens_in      = '0;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset mode", 64'(mode), 64'd0);
    chk("reset start_ready", 64'(start_ready), 64'd1);
    chk("reset result_valid", 64'(result_valid), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset data_in", 64'(data_in), 64'd0);

    for (int i = 0; i < 5; i++)
      run_job($sformatf("tbl%0d", i), tbl[i].board, tbl[i].gens, tbl[i].exp, 0);

    run_job("done_hold", 64'hA5A5_5A5A_0F0F_F0F0, 2, life_n(64'hA5A5_5A5A_0F0F_F0F0, 2), 20);

    start_only(64'h0000_0000_1C00_0000, 10);
    repeat (64 + 3) @(negedge clk);
    chk("mid_step mode", 64'(mode), 64'd2);
    reset = 1'b1;
    #1;
    chk("rst_step mode", 64'(mode), 64'd0);
    chk("rst_step busy", 64'(busy), 64'd0);
    chk("rst_step start_ready", 64'(start_ready), 64'd1);
    chk("rst_step result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst idle", 64'(start_ready), 64'd1);

    start_only(64'hFFFF_0000_FFFF_0000, 1);
    repeat (30) @(negedge clk);
    chk("mid_load mode", 64'(mode), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_load mode", 64'(mode), 64'd0);
    chk("rst_load data_in", 64'(data_in), 64'd0);
`ifdef CONWAY_HOST_POPCOUNT_EN
    chk("rst_load live_count", 64'(live_count), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    run_job("after_rst", 64'h0000_0000_1C00_0000, 1, 64'h0000_0008_0808_0000, 0);

    for (int i = 0; i < 8; i++) begin
      rb = {$urandom, $urandom};
      rg = $urandom_range(0, 5);
      run_job($sformatf("rand%0d", i), rb, rg, life_n(rb, rg), 2);
    end

    rb = {$urandom, $urandom};
    run_job("gens_max", rb, 255, life_n(rb, 255), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
